// File: rtl/muldiv_iter.sv
// muldiv_iter: radix-2 sequential RV32M/RV64M multiply/divide unit.
// One shift datapath serves shift-add multiply and restoring divide.
module muldiv_iter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_INIT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state;
    state_t state_nx;

    logic [2:0]       op_q;
    logic             neg_q;
    logic [CW-1:0]    cnt_q;
    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;
    logic [XLEN-1:0]  dv_q;
    logic [XLEN-1:0]  res_q;
    logic [TAG_W-1:0] tag_q;

    logic            is_div;
    logic            is_rem;
    logic            a_sgn;
    logic            b_sgn;
    logic            a_neg;
    logic            b_neg;
    logic            b_zero;
    logic            ovf;
    logic            special;
    logic            neg_in;
    logic            accept;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] spec_res;

    assign is_div = in_op[2];
    assign is_rem = in_op[2] & in_op[1];
    assign a_sgn  = in_op[2] ? ~in_op[0] : (in_op[1:0] != 2'b11);
    assign b_sgn  = in_op[2] ? ~in_op[0] : ~in_op[1];
    assign a_neg  = a_sgn & in_a[XLEN-1];
    assign b_neg  = b_sgn & in_b[XLEN-1];
    assign a_mag  = a_neg ? -in_a : in_a;
    assign b_mag  = b_neg ? -in_b : in_b;
    assign neg_in = is_rem ? a_neg : (a_neg ^ b_neg);
    assign b_zero = (in_b == '0);
    assign ovf    = a_sgn & (in_a == MIN_NEG) & (in_b == '1);
    assign special = is_div & (b_zero | ovf);
    assign accept = in_valid & in_ready & ~flush;

    // b==0 gives all-ones / dividend; signed overflow gives dividend / zero
    always_comb begin
        spec_res = '0;
        if (b_zero) begin
            spec_res = in_op[1] ? in_a : '1;
        end else begin
            spec_res = in_op[1] ? '0 : in_a;
        end
    end

    logic [XLEN:0]     msum;
    logic [XLEN:0]     dsh;
    logic [XLEN:0]     ddiff;
    logic              qbit;
    logic [XLEN-1:0]   hi_nx;
    logic [XLEN-1:0]   lo_nx;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fin;

    assign msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : '0);
    assign dsh   = {hi_q, lo_q[XLEN-1]};
    assign ddiff = dsh - {1'b0, dv_q};
    assign qbit  = ~ddiff[XLEN];

    // hi/lo hold product upper/lower, or remainder/quotient when dividing
    always_comb begin
        hi_nx = hi_q;
        lo_nx = lo_q;
        if (op_q[2]) begin
            hi_nx = qbit ? ddiff[XLEN-1:0] : dsh[XLEN-1:0];
            lo_nx = {lo_q[XLEN-2:0], qbit};
        end else begin
            hi_nx = msum[XLEN:1];
            lo_nx = {msum[0], lo_q[XLEN-1:1]};
        end
    end

    assign prod   = {hi_nx, lo_nx};
    assign prod_s = neg_q ? -prod : prod;
    assign quo    = neg_q ? -lo_nx : lo_nx;
    assign rem    = neg_q ? -hi_nx : hi_nx;

    always_comb begin
        fin = '0;
        unique case (1'b1)
            (op_q == 3'd0):             fin = prod_s[XLEN-1:0];
            (!op_q[2] && op_q != 3'd0): fin = prod_s[2*XLEN-1:XLEN];
            (op_q[2] && !op_q[1]):      fin = quo;
            (op_q[2] && op_q[1]):       fin = rem;
            default:                    fin = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (in_valid) state_nx = special ? DONE : CALC;
            CALC: if (cnt_q == '0) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: in_ready = 1'b1;
            CALC: busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            neg_q <= 1'b0;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            dv_q  <= '0;
            res_q <= '0;
            tag_q <= '0;
        end else if (accept) begin
            op_q  <= in_op;
            tag_q <= in_tag;
            neg_q <= neg_in;
            cnt_q <= CNT_INIT;
            hi_q  <= '0;
            lo_q  <= is_div ? a_mag : b_mag;
            dv_q  <= is_div ? b_mag : a_mag;
            if (special) res_q <= spec_res;
        end else if (state == CALC && !flush) begin
            hi_q <= hi_nx;
            lo_q <= lo_nx;
            if (cnt_q == '0) begin
                res_q <= fin;
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign out_result = res_q;
    assign out_tag    = tag_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: random and directed checks of muldiv_iter
// against a plain-arithmetic RV32M reference model.
module tb_muldiv_iter;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = '0;
    logic [XLEN-1:0]  in_a = '0;
    logic [XLEN-1:0]  in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    muldiv_iter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    function automatic logic [31:0] model(
        input logic [2:0] op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        longint sa;
        longint sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        int ia;
        int ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // edges after the accept edge until out_valid shows
    function automatic int exp_lat(
        input logic [2:0] op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic sp;
        sp = op[2] && (b == 0 ||
            (!op[0] && a == MIN_NEG && b == 32'hFFFF_FFFF));
        return sp ? 0 : XLEN;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(7))
            0: return 32'd0;
            1: return MIN_NEG;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(15));
            5: return -32'($urandom_range(15));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(
        input  logic [2:0]  op,
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  logic [4:0]  tag,
        output logic [31:0] res,
        output logic [4:0]  rtag,
        output int          lat
    );
        in_op = op;
        in_a = a;
        in_b = b;
        in_tag = tag;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op = 3'($urandom_range(7));
        in_a = $urandom;
        in_b = $urandom;
        in_tag = 5'($urandom_range(31));
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_result;
        rtag = out_tag;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            $display("FAIL reset_flags got %b want 100",
                {in_ready, out_valid, busy});
        end else passed++;
        checks++;
        if ({out_result, out_tag} !== '0) begin
            $display("FAIL reset_data got %h/%h want 0/0",
                out_result, out_tag);
        end else passed++;
    endtask

    task automatic test_directed();
        logic [2:0]  t_op [13];
        logic [31:0] t_a [13];
        logic [31:0] t_b [13];
        logic [31:0] t_e [13];
        logic [31:0] r;
        logic [4:0]  t;
        int lat;
        int el;
        t_op = '{3'd1, 3'd0, 3'd3, 3'd2, 3'd0, 3'd4, 3'd6,
                 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
        t_a = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                32'hFFFF_FFF9, 32'd7, 32'd7, 32'd5, 32'd5,
                32'h8000_0000, 32'h8000_0000};
        t_b = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                32'd2, 32'd2, 32'd0, 32'd0,
                32'hFFFF_FFFF, 32'hFFFF_FFFF};
        t_e = '{32'h4000_0000, 32'h0000_0000, 32'hFFFF_FFFE,
                32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFD,
                32'hFFFF_FFFF, 32'd3, 32'd1, 32'hFFFF_FFFF,
                32'd5, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 13; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], 5'(i + 3), r, t, lat);
            el = (i >= 9) ? 0 : XLEN;
            checks++;
            if (r !== t_e[i]) begin
                $display("FAIL dir_result[%0d] got %h want %h",
                    i, r, t_e[i]);
            end else passed++;
            checks++;
            if (t !== 5'(i + 3)) begin
                $display("FAIL dir_tag[%0d] got %0d want %0d",
                    i, t, i + 3);
            end else passed++;
            checks++;
            if (lat !== el) begin
                $display("FAIL dir_latency[%0d] got %0d want %0d",
                    i, lat, el);
            end else passed++;
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tg;
        logic [31:0] r;
        logic [4:0]  t;
        int lat;
        for (int i = 0; i < 200; i++) begin
            op = 3'($urandom_range(7));
            a = pick();
            b = pick();
            tg = 5'($urandom_range(31));
            run_op(op, a, b, tg, r, t, lat);
            checks++;
            if (r !== model(op, a, b) || t !== tg) begin
                $display("FAIL rnd op%0d %h,%h got %h/%0d want %h/%0d",
                    op, a, b, r, t, model(op, a, b), tg);
            end else passed++;
            checks++;
            if (lat !== exp_lat(op, a, b)) begin
                $display("FAIL rnd_latency op%0d got %0d want %0d",
                    op, lat, exp_lat(op, a, b));
            end else passed++;
        end
    endtask

    task automatic test_hold();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        int n;
        a = $urandom;
        b = $urandom;
        e = model(3'd3, a, b);
        out_ready = 1'b0;
        in_op = 3'd3;
        in_a = a;
        in_b = b;
        in_tag = 5'd21;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = ~a;
        in_tag = 5'd2;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, in_ready, out_result, out_tag} !==
                {1'b1, 1'b0, e, 5'd21}) begin
                $display("FAIL hold[%0d] v%b r%b %h/%0d want v1 r0 %h/21",
                    i, out_valid, in_ready, out_result, out_tag, e);
            end else passed++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            $display("FAIL hold_release got v%b r%b want v0 r1",
                out_valid, in_ready);
        end else passed++;
    endtask

    task automatic test_flush();
        logic seen;
        logic [31:0] r;
        logic [4:0]  t;
        int lat;
        in_op = 3'd5;
        in_a = $urandom;
        in_b = 32'd3;
        in_tag = 5'd9;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            $display("FAIL flush_calc got r%b b%b v%b want r1 b0 v0",
                in_ready, busy, out_valid);
        end else passed++;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            $display("FAIL flush_no_result got %b want 0", seen);
        end else passed++;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b0;
        checks++;
        if ({busy, in_ready} !== 2'b01) begin
            $display("FAIL flush_idle_req got b%b r%b want b0 r1",
                busy, in_ready);
        end else passed++;
        out_ready = 1'b0;
        in_op = 3'd5;
        in_a = 32'd5;
        in_b = 32'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            $display("FAIL flush_pre_done got %b want 1", out_valid);
        end else passed++;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        out_ready = 1'b1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            $display("FAIL flush_done got v%b r%b want v0 r1",
                out_valid, in_ready);
        end else passed++;
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd4, r, t, lat);
        checks++;
        if (r !== 32'hFFFF_FFFF || t !== 5'd4) begin
            $display("FAIL flush_after got %h/%0d want ffffffff/4",
                r, t);
        end else passed++;
    endtask

    task automatic test_reset_mid();
        logic seen;
        logic [31:0] r;
        logic [4:0]  t;
        int lat;
        in_op = 3'd1;
        in_a = $urandom;
        in_b = $urandom;
        in_tag = 5'd17;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, out_result, out_tag} !==
            {3'b100, 32'd0, 5'd0}) begin
            $display("FAIL rst_mid got r%b v%b b%b %h/%0d want r1 v0 b0 0/0",
                in_ready, out_valid, busy, out_result, out_tag);
        end else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            $display("FAIL rst_no_result got %b want 0", seen);
        end else passed++;
        run_op(3'd5, 32'd100, 32'd7, 5'd30, r, t, lat);
        checks++;
        if (r !== 32'd14 || t !== 5'd30) begin
            $display("FAIL rst_after got %h/%0d want 0000000e/30", r, t);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [4:0]  t;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready);
            end else passed++;
            op = 3'(i + 2);
            a = $urandom;
            b = 32'($urandom_range(1000) + 1);
            run_op(op, a, b, 5'(i), r, t, lat);
            checks++;
            if (r !== model(op, a, b) || t !== 5'(i)) begin
                $display("FAIL b2b[%0d] got %h/%0d want %h/%0d",
                    i, r, t, model(op, a, b), i);
            end else passed++;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
